// File: rtl/operand_fetch.sv
// operand_fetch: reads up to two source operands from a single-ported register
// file. Writebacks share the same port and win over a new request in IDLE.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   req_*                     - operand request (rs1, rs2, use_rs2) handshake
//   op_*                      - registered operand output handshake
//   wb_*                      - writeback handshake (rd, data)
//   rf_we/rf_addr/rf_wdata    - register file port (combinational, one access/cycle)
//   rf_rdata                  - register file read data (combinational from rf_addr)
module operand_fetch #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned REG_COUNT = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [$clog2(REG_COUNT)-1:0] req_rs1,
  input  logic [$clog2(REG_COUNT)-1:0] req_rs2,
  input  logic                         req_use_rs2,
  output logic                         op_valid,
  input  logic                         op_ready,
  output logic [WORD_SIZE-1:0]         op_a,
  output logic [WORD_SIZE-1:0]         op_b,
  input  logic                         wb_valid,
  output logic                         wb_ready,
  input  logic [$clog2(REG_COUNT)-1:0] wb_rd,
  input  logic [WORD_SIZE-1:0]         wb_data,
  output logic                         rf_we,
  output logic [$clog2(REG_COUNT)-1:0] rf_addr,
  output logic [WORD_SIZE-1:0]         rf_wdata,
  input  logic [WORD_SIZE-1:0]         rf_rdata
);

  localparam int unsigned AW = $clog2(REG_COUNT);

  typedef enum logic [1:0] {IDLE, RD1, RD2, HOLD} state_t;

  state_t                state_q;
  logic [AW-1:0]         rs1_q;
  logic [AW-1:0]         rs2_q;
  logic                  use_rs2_q;
  logic [WORD_SIZE-1:0]  op_a_q;
  logic [WORD_SIZE-1:0]  op_b_q;
  logic                  op_valid_q;
  logic                  wb_fire;

  // Handshake readiness: the port is free for writebacks only when not reading.
  always_comb begin
    wb_ready  = (state_q == IDLE) || (state_q == HOLD);
    req_ready = (state_q == IDLE) && !wb_valid;
    wb_fire   = wb_valid && wb_ready;
  end

  // Register file port mux: a read in RD1/RD2, otherwise an optional write.
  // Writes to x0 are accepted but never reach the port; rst kills any write.
  always_comb begin
    rf_we    = 1'b0;
    rf_addr  = '0;
    rf_wdata = '0;
    unique case (state_q)
      RD1: rf_addr = rs1_q;
      RD2: rf_addr = rs2_q;
      default: begin
        if (wb_fire && (wb_rd != '0)) begin
          rf_we    = !rst;
          rf_addr  = wb_rd;
          rf_wdata = wb_data;
        end
      end
    endcase
  end

  // Control FSM with registered operand outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      use_rs2_q  <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            rs1_q     <= req_rs1;
            rs2_q     <= req_rs2;
            use_rs2_q <= req_use_rs2;
            state_q   <= RD1;
          end
        end
        RD1: begin
          op_a_q <= rf_rdata;
          if (use_rs2_q) begin
            state_q <= RD2;
          end else begin
            op_b_q     <= '0;
            op_valid_q <= 1'b1;
            state_q    <= HOLD;
          end
        end
        RD2: begin
          op_b_q     <= rf_rdata;
          op_valid_q <= 1'b1;
          state_q    <= HOLD;
        end
        HOLD: begin
          // Operands were captured already, so HOLD writebacks cannot disturb them.
          if (op_ready) begin
            op_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_valid = op_valid_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter WORD_SIZE, 32, register width in bits.
REQ-002 Parameter REG_COUNT, 32, register count; AW = $clog2(REG_COUNT).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  1  operand-fetch request present.
REQ-006 req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-007 req_rs1  in  AW  first source register index.
REQ-008 req_rs2  in  AW  second source register index.
REQ-009 req_use_rs2  in  1  high = read rs2; low = op_b forced to 0.
REQ-010 op_valid  out  1  op_a/op_b valid.
REQ-011 op_ready  in  1  consumer takes operands.
REQ-012 op_a  out  WORD_SIZE  value of rs1.
REQ-013 op_b  out  WORD_SIZE  value of rs2, or 0.
REQ-014 wb_valid  in  1  writeback request present.
REQ-015 wb_ready  out  1  writeback accepted this cycle when high with wb_valid.
REQ-016 wb_rd  in  AW  destination register index.
REQ-017 wb_data  in  WORD_SIZE  writeback value.
REQ-018 rf_we  out  1  register file write enable.
REQ-019 rf_addr  out  AW  register file shared read/write address.
REQ-020 rf_wdata  out  WORD_SIZE  register file write data.
REQ-021 rf_rdata  in  WORD_SIZE  register file read data, combinational from rf_addr, index 0 reads 0.

Function
REQ-022 The FSM SHALL have states IDLE, RD1, RD2, HOLD.
REQ-023 The register file port SHALL be driven by exactly one access per cycle: a write, a read, or nothing (rf_we=0, rf_addr=0).
REQ-024 In IDLE and HOLD, wb_ready SHALL be 1; in RD1 and RD2, wb_ready SHALL be 0.
REQ-025 An accepted writeback SHALL drive rf_addr=wb_rd, rf_wdata=wb_data, and rf_we=1 in the same cycle, except that wb_rd=0 SHALL give rf_we=0 (accepted and discarded).
REQ-026 In IDLE, req_ready SHALL equal !wb_valid, so writeback has priority over a new request.
REQ-027 On request acceptance, the block SHALL latch rs1, rs2, and use_rs2, and move to RD1.
REQ-028 In RD1, the block SHALL drive rf_addr=rs1 and capture rf_rdata into op_a at the clock edge; next state is RD2 if use_rs2, else HOLD with op_b loaded to 0.
REQ-029 In RD2, the block SHALL drive rf_addr=rs2, capture rf_rdata into op_b, and move to HOLD.
REQ-030 In HOLD, op_valid SHALL be 1, with op_a/op_b stable until op_ready; op_valid&op_ready SHALL return the FSM to IDLE.
REQ-031 Latency from acceptance edge T to op_valid SHALL be: asserted in cycle T+3 with use_rs2, T+2 without.
REQ-032 Writebacks accepted in HOLD SHALL NOT alter the latched op_a/op_b, even when wb_rd equals rs1/rs2.
REQ-033 A writeback accepted in the same IDLE cycle where req_valid is held SHALL be visible to the later read (read-after-write ordering).
REQ-034 req_ready SHALL be 0 in RD1, RD2, HOLD; no request is queued.
REQ-035 rs1==rs2 SHALL still perform two reads; both operands SHALL equal the same value.

Reset
REQ-036 Asserting rst SHALL immediately force state IDLE, op_valid=0, op_a=0, op_b=0, and rf_we=0, independent of clk.
REQ-037 Reset mid-operation SHALL drop the in-flight request with no rf write and no op_valid.

Verification
REQ-038 Preload x5=0x11, x6=0x22; request rs1=5, rs2=6, use_rs2=1 -> op_valid at T+3, op_a=0x11, op_b=0x22.
REQ-039 Request rs1=5, use_rs2=0 -> op_valid at T+2, op_a=0x11, op_b=0.
REQ-040 wb_valid (rd=5, data=0xAA) and req_valid (rs1=5) in the same IDLE cycle -> write first, req accepted next cycle, op_a=0xAA.
REQ-041 Writeback rd=0, data=0xFFFF -> wb_ready=1, rf_we=0, later read of x0 gives 0.
REQ-042 In HOLD with op_ready=0 for 4 cycles, writeback rd=5 data=0x99 -> op_a remains 0x11 throughout; after release, new read gives 0x99.
REQ-043 rst pulsed during RD2 -> op_valid=0, op_a=op_b=0, state IDLE, req_ready=1 next cycle.
